ssd_capture: RTL and testbench

Seven-segment bus capture and decode block: samples a multiplexed, active-low seven-segment bus (segment lines plus digit-select anodes) and rebuilds the BCD value shown at each digit position. It sits on the receive side of the display interface produced by the team's segment drivers. Typical uses are self-checking the display path on-board and feeding displayed values back to a logic analyzer or UART. A stability filter rejects ghosting during anode switching, and invalid patterns are flagged per digit.

---
 rtl/ssd_capture.sv | 164 ++++++++++++++++
 tb/tb_ssd_capture.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_capture.sv
// ssd_capture: samples a multiplexed active-low seven-segment bus and rebuilds
// the BCD value shown at each anode position, with a stability filter
// against anode-switch ghosting and per-position sticky error flags.
// Optional feature macro: SSD_CAP_ALLON_EN (all-low an_in = broadcast to all).
module ssd_capture #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [0:6]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    capture_en,
  input  logic                    clear_err,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   valid_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    update_strobe
);

  localparam int unsigned SW = NUM_DIGITS + 7;
  localparam int unsigned CW = 8;
  localparam int unsigned OW = $clog2(NUM_DIGITS + 1);
  localparam int unsigned VW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);

  // Decode an abcdefg (0 = lit) pattern: 0..9 digit, F blank, E undecodable
  function automatic logic [3:0] seg_decode(input logic [0:6] s);
    logic [3:0] d;
    case (s)
      7'b0000001: d = 4'd0;
      7'b1001111: d = 4'd1;
      7'b0010010: d = 4'd2;
      7'b0000110: d = 4'd3;
      7'b1001100: d = 4'd4;
      7'b0100100: d = 4'd5;
      7'b0100000: d = 4'd6;
      7'b0001111: d = 4'd7;
      7'b0000000: d = 4'd8;
      7'b0000100: d = 4'd9;
      7'b1111111: d = 4'hF;
      default:    d = 4'hE;
    endcase
    return d;
  endfunction

  logic [SW-1:0]         smp_c;
  logic [SW-1:0]         smp_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic [NUM_DIGITS-1:0] sel_c;
  logic [OW-1:0]         ones_c;
  logic                  addr_c;
  logic                  commit_c;

  logic                  cmt_q;
  logic [NUM_DIGITS-1:0] cmt_mask_q;
  logic [0:6]            cmt_seg_q;

  logic [VW-1:0]         val_q;
  logic [VW-1:0]         val_d;
  logic [NUM_DIGITS-1:0] vld_q;
  logic [NUM_DIGITS-1:0] vld_d;
  logic [NUM_DIGITS-1:0] err_q;
  logic [NUM_DIGITS-1:0] err_set_c;
  logic [3:0]            code_c;
  logic                  upd_c;
  logic                  strobe_q;

  assign smp_c = {an_in, seg_in};
  assign sel_c = ~an_in;

  // Sample classification: one selected anode (or all, as broadcast) is addressed
  always_comb begin
    ones_c = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      ones_c = ones_c + OW'(sel_c[i]);
    end
    addr_c = (ones_c == OW'(1));
`ifdef SSD_CAP_ALLON_EN
    if (an_in == '0) begin
      addr_c = 1'b1;
    end
`endif
  end

  // Stability counter next state and single-shot commit detection
  always_comb begin
    cnt_d    = '0;
    commit_c = 1'b0;
    if (capture_en && addr_c) begin
      if (smp_c == smp_q) begin
        cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
      end else begin
        cnt_d = CW'(1);
      end
      commit_c = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
    end
  end

  // Sample history, counter and the registered commit request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q      <= '1;
      cnt_q      <= '0;
      cmt_q      <= 1'b0;
      cmt_mask_q <= '0;
      cmt_seg_q  <= '1;
    end else begin
      smp_q <= smp_c;
      cnt_q <= cnt_d;
      cmt_q <= commit_c;
      if (commit_c) begin
        cmt_mask_q <= sel_c;
        cmt_seg_q  <= seg_in;
      end
    end
  end

  // Apply a committed pattern to every selected position
  always_comb begin
    val_d     = val_q;
    vld_d     = vld_q;
    err_set_c = '0;
    code_c    = seg_decode(cmt_seg_q);
    if (cmt_q) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (cmt_mask_q[i]) begin
          if (code_c <= 4'd9) begin
            val_d[4*i +: 4] = code_c;
            vld_d[i]        = 1'b1;
          end else if (code_c == 4'hF) begin
            val_d[4*i +: 4] = 4'hF;
            vld_d[i]        = 1'b0;
          end else begin
            err_set_c[i] = 1'b1;
          end
        end
      end
    end
    upd_c = (val_d != val_q) || (vld_d != vld_q);
  end

  // Output registers; a new error set overrides a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q    <= '1;
      vld_q    <= '0;
      err_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      val_q    <= val_d;
      vld_q    <= vld_d;
      err_q    <= (clear_err ? '0 : err_q) | err_set_c;
      strobe_q <= upd_c;
    end
  end

  assign value_out     = val_q;
  assign valid_out     = vld_q;
  assign err_out       = err_q;
  assign update_strobe = strobe_q;

endmodule

// File: tb/tb_ssd_capture.sv
// Scoreboard bench for ssd_capture (NUM_DIGITS=8, STABLE_CNT=4).
module tb_ssd_capture;

  localparam int N      = 8;
  localparam int STABLE = 4;
`ifdef SSD_CAP_ALLON_EN
  localparam bit ALLON = 1'b1;
`else
  localparam bit ALLON = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [0:6]    seg_in;
  logic [N-1:0]  an_in;
  logic          capture_en;
  logic          clear_err;
  logic [4*N-1:0] value_out;
  logic [N-1:0]  valid_out;
  logic [N-1:0]  err_out;
  logic          update_strobe;

  ssd_capture #(.NUM_DIGITS(N), .STABLE_CNT(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
    .capture_en(capture_en), .clear_err(clear_err),
    .value_out(value_out), .valid_out(valid_out), .err_out(err_out),
    .update_strobe(update_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] v;
    logic [7:0]  d;
  } exp_t;

  exp_t        sbq[$];
  int unsigned nvec = 0;
  int unsigned nerr = 0;
  int unsigned nstrobe = 0;

  logic [31:0] m_val;
  logic [7:0]  m_vld;
  logic [7:0]  m_err;
  logic [7:0]  pend;

  logic [6:0] segtab [10];
  initial begin
    segtab[0] = 7'b0000001; segtab[1] = 7'b1001111; segtab[2] = 7'b0010010;
    segtab[3] = 7'b0000110; segtab[4] = 7'b1001100; segtab[5] = 7'b0100100;
    segtab[6] = 7'b0100000; segtab[7] = 7'b0001111; segtab[8] = 7'b0000000;
    segtab[9] = 7'b0000100;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [6:0] s);
    for (int k = 0; k < 10; k++) begin
      if (segtab[k] == s) return k;
    end
    return 15;
  endfunction

  // Drive one pattern for n cycles and advance the reference model
  task automatic drive(input logic [7:0] an, input logic [6:0] seg, input int n,
                       input logic clr, input logic en);
    logic [7:0]  mask;
    logic        hit;
    logic [31:0] nv;
    logic [7:0]  nd;
    int          code;
    if (clr) m_err = pend;
    pend = '0;
    mask = ~an;
    hit  = ($countones(mask) == 1) || (ALLON && an == 8'h00);
    if (en && hit && n >= STABLE) begin
      nv   = m_val;
      nd   = m_vld;
      code = lookup(seg);
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          if (code < 10) begin
            nv[4*i +: 4] = 4'(code);
            nd[i]        = 1'b1;
          end else if (seg == 7'h7F) begin
            nv[4*i +: 4] = 4'hF;
            nd[i]        = 1'b0;
          end else begin
            m_err[i] = 1'b1;
            if (n == STABLE) pend[i] = 1'b1;
          end
        end
      end
      if ({nv, nd} != {m_val, m_vld}) sbq.push_back({nv, nd});
      m_val = nv;
      m_vld = nd;
    end
    an_in      = an;
    seg_in     = seg;
    clear_err  = clr;
    capture_en = en;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(8'hFF, 7'h7F, n, 1'b0, 1'b1);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_value"}, 64'(value_out), 64'(m_val));
    chk({tag, "_valid"}, 64'(valid_out), 64'(m_vld));
    chk({tag, "_err"},   64'(err_out),   64'(m_err));
  endtask

  // Scoreboard consumer: every strobe must match the next expected update
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && update_strobe) begin
      nstrobe++;
      if (sbq.size() == 0) begin
        chk("strobe_unexpected", 64'(1), 64'(0));
      end else begin
        e = sbq.pop_front();
        chk("sb_value", 64'(value_out), 64'(e.v));
        chk("sb_valid", 64'(valid_out), 64'(e.d));
      end
    end
  end

  initial begin
    int unsigned s0;
    m_val = 32'hFFFF_FFFF;
    m_vld = '0;
    m_err = '0;
    pend  = '0;
    rst_n = 1'b0;
    an_in = 8'hFF;
    seg_in = 7'h7F;
    capture_en = 1'b1;
    clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value",  64'(value_out), 64'h0000_0000_FFFF_FFFF);
    chk("rst_valid",  64'(valid_out), 64'h0);
    chk("rst_err",    64'(err_out),   64'h0);
    chk("rst_strobe", 64'(update_strobe), 64'h0);
    rst_n = 1'b1;
    idle(2);

    // single digit on position 0
    s0 = nstrobe;
    drive(8'hFE, segtab[2], 5, 1'b0, 1'b1);
    idle(3);
    check_state("single");
    chk("single_strobes", 64'(nstrobe - s0), 64'(1));

    // scan 7..0 across positions, then repeat identically
    s0 = nstrobe;
    for (int p = 0; p < N; p++) drive(~(8'h01 << p), segtab[7-p], 6, 1'b0, 1'b1);
    idle(3);
    check_state("scan1");
    chk("scan1_value", 64'(value_out), 64'h0123_4567);
    chk("scan1_strobes", 64'(nstrobe - s0), 64'(8));
    s0 = nstrobe;
    for (int p = 0; p < N; p++) drive(~(8'h01 << p), segtab[7-p], 6, 1'b0, 1'b1);
    idle(3);
    chk("scan2_strobes", 64'(nstrobe - s0), 64'(0));

    // glitch on position 3: short dwell rejected, following stable pattern taken
    drive(8'hF7, segtab[9], 3, 1'b0, 1'b1);
    drive(8'hF7, segtab[1], 4, 1'b0, 1'b1);
    idle(3);
    check_state("glitch");

    // invalid pattern on position 5, clear, and set-wins-over-clear
    drive(8'hDF, 7'b1111110, 6, 1'b0, 1'b1);
    idle(2);
    check_state("err_set");
    drive(8'hFF, 7'h7F, 1, 1'b1, 1'b1);
    idle(1);
    check_state("err_clr");
    drive(8'hDF, 7'b1111110, 4, 1'b0, 1'b1);
    drive(8'hFF, 7'h7F, 1, 1'b1, 1'b1);
    idle(2);
    check_state("err_setwins");
    drive(8'hFF, 7'h7F, 1, 1'b1, 1'b1);
    idle(1);

    // blank on position 0, then capture disabled
    drive(8'hFE, 7'h7F, 6, 1'b0, 1'b1);
    idle(2);
    check_state("blank");
    drive(8'hFB, segtab[8], 6, 1'b0, 1'b0);
    idle(2);
    check_state("cap_off");

    // all anodes low
    drive(8'h00, 7'b0000000, 5, 1'b0, 1'b1);
    idle(3);
    check_state("allon");

    idle(3);
    chk("sb_drain", 64'(sbq.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
